// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock serial time-entry path.
// BCD time layout, ASCII frame symbols, range limits and FSM encodings.
package alarm_clock_pkg;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] min;
    logic [7:0] sec;
  } bcd_time_t;

  localparam logic [7:0] HDR_CLOCK  = 8'h54;
  localparam logic [7:0] HDR_ALARM  = 8'h41;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  localparam logic [7:0] MAX_HR_BCD = 8'h23;
  localparam logic [7:0] MAX_MS_BCD = 8'h59;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_DIGITS,
    P_WAIT_CR
  } parse_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampling UART byte receiver: rx synchronizer, tick divider, byte FSM.
// Define TIME_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx_byte
  import alarm_clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int DIV  = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW   = $clog2(OVERSAMPLE);
  localparam int HALF = OVERSAMPLE / 2;

  logic [1:0]    r_sync;
  logic          w_rx;
  logic [DW-1:0] r_div;
  logic          w_tick;
  rx_state_t     r_state;
  rx_state_t     w_state_n;
  logic [TW-1:0] r_tcnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic          r_err;
  logic          w_samp;
`ifdef TIME_RX_PARITY_EN
  logic          r_par_bad;
`endif

  assign w_rx       = r_sync[1];
  assign w_tick     = (r_div == DW'(DIV - 1));
  assign data       = r_shift;
  assign byte_valid = r_valid;
  assign byte_err   = r_err;

  // two-flop synchronizer, idles high
  always_ff @(posedge CLK) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx};
  end

  // free-running oversample tick divider
  always_ff @(posedge CLK) begin
    if (reset || w_tick) r_div <= '0;
    else                 r_div <= r_div + 1'b1;
  end

  // byte FSM state register
  always_ff @(posedge CLK) begin
    if (reset) r_state <= RX_IDLE;
    else       r_state <= w_state_n;
  end

  // byte FSM next state
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      RX_IDLE:  if (!w_rx) w_state_n = RX_START;
      RX_START: if (w_samp) w_state_n = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (w_samp && r_bit == 3'd7) begin
`ifdef TIME_RX_PARITY_EN
          w_state_n = RX_PARITY;
`else
          w_state_n = RX_STOP;
`endif
        end
`ifdef TIME_RX_PARITY_EN
      RX_PARITY: if (w_samp) w_state_n = RX_STOP;
`endif
      RX_STOP:  if (w_samp) w_state_n = RX_IDLE;
      default:  w_state_n = RX_IDLE;
    endcase
  end

  // sample point: half a bit into start, full bit elsewhere
  always_comb begin
    w_samp = 1'b0;
    case (r_state)
      RX_IDLE:  w_samp = 1'b0;
      RX_START: w_samp = w_tick && (r_tcnt == TW'(HALF - 1));
      default:  w_samp = w_tick && (r_tcnt == TW'(OVERSAMPLE - 1));
    endcase
  end

  // tick counting, shift register and result pulses
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_tcnt    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
`ifdef TIME_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == RX_IDLE || w_samp) r_tcnt <= '0;
      else if (w_tick)                  r_tcnt <= r_tcnt + 1'b1;
      if (w_samp) begin
        case (r_state)
          RX_START: begin
            r_bit     <= '0;
`ifdef TIME_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
          end
          RX_DATA: begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
          end
`ifdef TIME_RX_PARITY_EN
          RX_PARITY: r_par_bad <= (w_rx != ^r_shift);
          RX_STOP: begin
            r_valid <= w_rx && !r_par_bad;
            r_err   <= !(w_rx && !r_par_bad);
          end
`else
          RX_STOP: begin
            r_valid <= w_rx;
            r_err   <= !w_rx;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/time_set_uart_rx.sv
// Serial time-entry receiver: parses "T/A HHMMSS CR", range-checks, loads.
// TIME_RX_PARITY_EN (in uart_rx_byte) adds an even-parity bit per byte.
module time_set_uart_rx
  import alarm_clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        rx,
  output logic [23:0] time_out,
  output logic        load_clock,
  output logic        load_alarm,
  output logic        frame_err,
  output logic        busy
);

  logic [7:0]   w_data;
  logic         w_bv;
  logic         w_be;
  parse_state_t r_state;
  parse_state_t w_state_n;
  logic [23:0]  r_digits;
  logic [2:0]   r_cnt;
  logic         r_tgt_alarm;
  bcd_time_t    r_time;
  logic         r_ld_clk;
  logic         r_ld_alm;
  logic         r_ferr;
  logic         w_is_hdr;
  logic         w_hdr;
  logic         w_dig;
  logic         w_acc;
  logic         w_err;
  bcd_time_t    w_cand;

  uart_rx_byte #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx (
    .CLK        (CLK),
    .reset      (reset),
    .rx         (rx),
    .data       (w_data),
    .byte_valid (w_bv),
    .byte_err   (w_be)
  );

  assign w_is_hdr   = (w_data == HDR_CLOCK) || (w_data == HDR_ALARM);
  assign w_cand     = bcd_time_t'(r_digits);
  assign time_out   = r_time;
  assign load_clock = r_ld_clk;
  assign load_alarm = r_ld_alm;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != P_IDLE);

  // parser state register
  always_ff @(posedge CLK) begin
    if (reset) r_state <= P_IDLE;
    else       r_state <= w_state_n;
  end

  // parser next state and per-byte decisions
  always_comb begin
    w_state_n = r_state;
    w_hdr     = 1'b0;
    w_dig     = 1'b0;
    w_acc     = 1'b0;
    w_err     = 1'b0;
    if (w_be) begin
      w_err     = 1'b1;
      w_state_n = P_IDLE;
    end else if (w_bv) begin
      unique case (r_state)
        P_IDLE:
          if (w_is_hdr) begin
            w_hdr     = 1'b1;
            w_state_n = P_DIGITS;
          end
        P_DIGITS:
          if (is_digit(w_data)) begin
            w_dig = 1'b1;
            if (r_cnt == 3'd5) w_state_n = P_WAIT_CR;
          end else if (w_is_hdr) begin
            w_err = 1'b1;
            w_hdr = 1'b1;
          end else begin
            w_err     = 1'b1;
            w_state_n = P_IDLE;
          end
        P_WAIT_CR: begin
          w_state_n = P_IDLE;
          if (w_data == ASCII_CR &&
              w_cand.hr  <= MAX_HR_BCD &&
              w_cand.min <= MAX_MS_BCD &&
              w_cand.sec <= MAX_MS_BCD)
            w_acc = 1'b1;
          else
            w_err = 1'b1;
        end
        default: w_state_n = P_IDLE;
      endcase
    end
  end

  // digit capture, time register and strobes
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_digits    <= '0;
      r_cnt       <= '0;
      r_tgt_alarm <= 1'b0;
      r_time      <= '0;
      r_ld_clk    <= 1'b0;
      r_ld_alm    <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_ld_clk <= w_acc && !r_tgt_alarm;
      r_ld_alm <= w_acc && r_tgt_alarm;
      r_ferr   <= w_err;
      if (w_hdr) begin
        r_tgt_alarm <= (w_data == HDR_ALARM);
        r_cnt       <= '0;
      end
      if (w_dig) begin
        r_digits <= {r_digits[19:0], w_data[3:0]};
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_acc) r_time <= w_cand;
    end
  end

endmodule

// File: tb/tb_time_set_uart_rx.sv
// Scoreboard bench for time_set_uart_rx at a scaled-down clock rate.
// Strobes are matched in order against expectations queued with stimulus.
module tb_time_set_uart_rx;

  localparam int CLK_HZ = 307200;
  localparam int BAUD   = 9600;
  localparam int OS     = 16;
  localparam int BITC   = (CLK_HZ / (BAUD * OS)) * OS;

  localparam int EV_CLK = 0;
  localparam int EV_ALM = 1;
  localparam int EV_ERR = 2;

  typedef struct {
    int          kind;
    logic [23:0] t;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [23:0] time_out;
  logic        load_clock;
  logic        load_alarm;
  logic        frame_err;
  logic        busy;

  int  total = 0;
  int  bad = 0;
  ev_t q[$];

  time_set_uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .CLK        (clk),
    .reset      (reset),
    .rx         (rx),
    .time_out   (time_out),
    .load_clock (load_clock),
    .load_alarm (load_alarm),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: sim did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // match every strobe against the head of the expectation queue
  always @(negedge clk) begin
    if (load_clock || load_alarm || frame_err) begin
      ev_t e;
      int  k;
      k = load_clock ? EV_CLK : (load_alarm ? EV_ALM : EV_ERR);
      total++;
      if (int'(load_clock) + int'(load_alarm) + int'(frame_err) > 1) begin
        bad++;
        $display("FAIL strobe_onehot: got clk=%b alm=%b err=%b, want one",
                 load_clock, load_alarm, frame_err);
      end
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got kind=%0d t=%h, want none",
                 k, time_out);
      end else begin
        e = q.pop_front();
        if (k !== e.kind ||
            (k != EV_ERR && time_out !== e.t)) begin
          bad++;
          $display("FAIL strobe: got kind=%0d t=%h, want kind=%0d t=%h",
                   k, time_out, e.kind, e.t);
        end
      end
    end
  end

  task automatic push(input int kind, input logic [23:0] t);
    ev_t e;
    e.kind = kind;
    e.t    = t;
    q.push_back(e);
  endtask

  task automatic hold(input logic v, input int bits);
    rx = v;
    repeat (bits * BITC) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok,
                           input logic par_ok);
    hold(1'b0, 1);
    for (int i = 0; i < 8; i++) hold(b[i], 1);
`ifdef TIME_RX_PARITY_EN
    hold((^b) ^ !par_ok, 1);
`endif
    hold(stop_ok, 1);
    rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d pending, want 0", name, q.size());
      q.delete();
    end
    repeat (2 * BITC) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({time_out, load_clock, load_alarm, frame_err, busy} !== 28'h0) begin
      bad++;
      $display("FAIL reset: got t=%h lc=%b la=%b fe=%b busy=%b, want zeros",
               time_out, load_clock, load_alarm, frame_err, busy);
    end
  endtask

  task automatic test_clock;
    push(EV_CLK, 24'h123456);
    send_str("T");
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_hdr: got %b, want 1", busy);
    end
    send_str("123456\r");
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_end: got %b, want 0", busy);
    end
    drain("clock");
    total++;
    if (time_out !== 24'h123456) begin
      bad++;
      $display("FAIL clock_time: got %h, want 123456", time_out);
    end
  endtask

  task automatic test_alarm;
    push(EV_ALM, 24'h070000);
    send_str("A070000\r");
    drain("alarm");
    total++;
    if (time_out !== 24'h070000) begin
      bad++;
      $display("FAIL alarm_time: got %h, want 070000", time_out);
    end
  endtask

  task automatic test_range;
    push(EV_ERR, 24'h0);
    send_str("T246000\r");
    drain("range");
    total++;
    if (time_out !== 24'h070000) begin
      bad++;
      $display("FAIL range_hold: got %h, want 070000", time_out);
    end
  endtask

  task automatic test_restart;
    push(EV_ERR, 24'h0);
    push(EV_ALM, 24'h063000);
    send_str("T12A063000\r");
    drain("restart");
    total++;
    if (time_out !== 24'h063000) begin
      bad++;
      $display("FAIL restart_time: got %h, want 063000", time_out);
    end
  endtask

  task automatic test_bad_stop;
    push(EV_ERR, 24'h0);
    send_str("T12");
    send_byte("3", 1'b0, 1'b1);
    hold(1'b1, 12);
    send_str("456\r");
    total++;
    if (time_out !== 24'h063000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL badstop_hold: got t=%h busy=%b, want 063000 0",
               time_out, busy);
    end
    push(EV_CLK, 24'h000001);
    send_str("T000001\r");
    drain("badstop");
    total++;
    if (time_out !== 24'h000001) begin
      bad++;
      $display("FAIL badstop_next: got %h, want 000001", time_out);
    end
  endtask

  task automatic test_reset_mid;
    send_str("T1234");
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy: got %b, want 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || time_out !== 24'h0) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b t=%h, want 0 000000",
               busy, time_out);
    end
    send_str("56\r");
    drain("midreset");
    total++;
    if (busy !== 1'b0 || time_out !== 24'h0) begin
      bad++;
      $display("FAIL mid_after: got busy=%b t=%h, want 0 000000",
               busy, time_out);
    end
  endtask

`ifdef TIME_RX_PARITY_EN
  task automatic test_parity;
    push(EV_ERR, 24'h0);
    send_str("T");
    send_byte("1", 1'b1, 1'b0);
    send_str("23456\r");
    drain("parity");
    total++;
    if (time_out !== 24'h0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL parity_hold: got t=%h busy=%b, want 000000 0",
               time_out, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clock();
    test_alarm();
    test_range();
    test_restart();
    test_bad_stop();
    test_reset_mid();
`ifdef TIME_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_uart_rx.md
# time_set_uart_rx

Serial time-entry receiver for the alarm clock. It accepts ASCII set commands on a UART line, validates them as BCD HHMMSS, and emits a 24-bit BCD time with a one-cycle load strobe aimed at either the running clock or the alarm register. It is the input-direction counterpart to the seven-segment display path: time arrives as text, is checked, and is handed to the clock core alongside the KEY/SW setting logic.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BAUD, 9600, serial bit rate
- OVERSAMPLE, 16, sample ticks per bit (even, ≥8)

- CLK  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high; clears all state
- rx  in  1  async serial input, idle high, 8 data bits, LSB first, 1 stop bit
- time_out  out  24  BCD {HH,MM,SS} of last valid frame; reset 24'h000000
- load_clock  out  1  one-cycle strobe, frame targeted clock; reset 0
- load_alarm  out  1  one-cycle strobe, frame targeted alarm; reset 0
- frame_err  out  1  one-cycle strobe on any rejected byte or frame; reset 0
- busy  out  1  high while the parser is not IDLE; reset 0

## Operation
- rx passes through a 2-FF synchronizer; all decisions use the synchronized bit.
- Tick divider: period = CLK_HZ/(BAUD*OVERSAMPLE), integer-truncated; counter wraps to 0.
- Byte RX FSM: IDLE → START on a sync-rx low. At tick OVERSAMPLE/2, still low → DATA; high → false start, back to IDLE with no error. DATA samples 8 bits every OVERSAMPLE ticks, LSB first → STOP. At STOP mid-sample: high → byte_valid pulse; low → byte_err pulse. Either way → IDLE.
- Frame format: header 'T' (0x54, clock) or 'A' (0x41, alarm), then six digits '0'–'9' (0x30–0x39), then CR (0x0D).
- Parser FSM:
  - IDLE: header → DIGITS, capture target, digit count=0. Any other byte is ignored without error.
  - DIGITS: digit → store (byte−0x30) into nibble position count (H tens first). After the 6th digit → WAIT_CR. A header byte raises frame_err and restarts DIGITS with the new target. Any other byte raises frame_err → IDLE.
  - WAIT_CR: CR → range check HH≤23, MM≤59, SS≤59. Pass: update time_out and pulse the target strobe. Fail: frame_err. Both → IDLE. Any non-CR byte raises frame_err → IDLE.
- byte_err in any state: frame_err, parser → IDLE.
- time_out changes only on an accepted frame and holds otherwise. At most one of the three strobes is high in any cycle.
- Reset mid-frame discards the partial frame and produces no strobe. Reset wins over a simultaneous byte_valid.

## Timing
- Strobe/time_out latency: 1 CLK after the internal byte_valid for CR. byte_valid occurs at the stop-bit mid-sample.
- End-to-end: stop-bit centre + 2 sync cycles + 1 cycle.
- frame_err is asserted 1 CLK after the offending byte_valid or byte_err.
- busy rises the cycle after header acceptance. It falls in the same cycle as the terminating strobe or error.
- Back-to-back frames with no idle gap are supported. The next start bit may follow the stop bit immediately.

## Configuration
- TIME_RX_PARITY_EN defined: the RX FSM expects an even-parity bit between bit 7 and stop. A parity mismatch produces byte_err, which causes frame_err and a parser reset. Frame length is 11 bit-times.
- Undefined: no parity bit, 10 bit-times per frame, no parity logic synthesized.

## Structure
- Shared package alarm_clock_pkg:
  - typedef for the 24-bit BCD time {hr,min,sec}
  - ASCII constants HDR_CLOCK, HDR_ALARM, ASCII_CR, ASCII_ZERO
  - limits MAX_HR_BCD=8'h23, MAX_MS_BCD=8'h59
- One sub-module, uart_rx_byte: synchronizer, tick divider, and byte RX FSM. It outputs data[7:0], byte_valid, and byte_err. The parser and range check stay in the top module.

## Test plan
- "T123456\r" at 9600 baud → time_out=24'h123456, load_clock high exactly 1 cycle, load_alarm=0, frame_err=0.
- "A070000\r" → time_out=24'h070000, single load_alarm pulse.
- "T246000\r" → one frame_err at CR, time_out unchanged, no load strobe.
- "T12A063000\r" → one frame_err at 'A', then load_alarm with time_out=24'h063000.
- "T123456\r" with byte 3's stop bit forced low → frame_err, no strobe. An immediately following "T000001\r" → load_clock, time_out=24'h000001.
- "T1234", then reset pulsed for 1 cycle, then "56\r" → no strobe, busy=0 after reset, time_out stays 24'h000000. With TIME_RX_PARITY_EN, a bad parity bit on any byte → frame_err, no strobe.
